// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered W-bit ALU with valid/ready handshake; iterative MUL when ALU_MUL_EN is defined
module alu_seq #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] inputA,
   input  logic [W-1:0] inputB,
   input  logic         carryIn,
   input  logic [2:0]   func,
   output logic         out_valid,
   output logic [W-1:0] result,
   output logic         carryOut,
   output logic         zero,
   output logic         negetive
);

   localparam logic [2:0] F_ADD = 3'b000;
   localparam logic [2:0] F_SUB = 3'b001;
   localparam logic [2:0] F_AND = 3'b010;
   localparam logic [2:0] F_OR  = 3'b011;
   localparam logic [2:0] F_XOR = 3'b100;
   localparam logic [2:0] F_SHL = 3'b101;
   localparam logic [2:0] F_SHR = 3'b110;
   localparam logic [2:0] F_MUL = 3'b111;

   logic         accept;
   logic [W:0]   sum_add;
   logic [W:0]   sum_sub;
   logic [W-1:0] op_res;
   logic         op_carry;

   // completion strobe and the value it publishes
   logic         done;
   logic [W-1:0] done_res;
   logic         done_carry;

   logic [W-1:0] result_q, result_d;
   logic         carry_q, carry_d;
   logic         zero_q, zero_d;
   logic         neg_q, neg_d;
   logic         out_valid_q, out_valid_d;

   assign accept  = in_valid && in_ready;
   assign sum_add = {1'b0, inputA} + {1'b0, inputB} + {{W{1'b0}}, carryIn};
   assign sum_sub = {1'b0, inputA} + {1'b0, ~inputB} + {{W{1'b0}}, carryIn};

   // single-cycle operations; the MUL slot yields zero and is overridden by the iterative path when built
   always_comb begin
      op_res   = '0;
      op_carry = 1'b0;
      case (func)
         F_ADD: begin
            op_res   = sum_add[W-1:0];
            op_carry = sum_add[W];
         end
         F_SUB: begin
            op_res   = sum_sub[W-1:0];
            op_carry = sum_sub[W];
         end
         F_AND: op_res = inputA & inputB;
         F_OR:  op_res = inputA | inputB;
         F_XOR: op_res = inputA ^ inputB;
         F_SHL: begin
            op_res   = {inputA[W-2:0], carryIn};
            op_carry = inputA[W-1];
         end
         F_SHR: begin
            op_res   = {carryIn, inputA[W-1:1]};
            op_carry = inputA[0];
         end
         F_MUL: begin
            op_res   = '0;
            op_carry = 1'b0;
         end
         default: begin
            op_res   = '0;
            op_carry = 1'b0;
         end
      endcase
   end

`ifdef ALU_MUL_EN
   localparam int CW = $clog2(W + 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [2*W-1:0]  mcand_q, mcand_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    mplier_q, mplier_d;
   logic [CW-1:0]   count_q, count_d;
   logic [2*W-1:0]  pp0;
   logic [2*W-1:0]  pp1;
   logic [2*W-1:0]  prod_final;

   // The accept edge only loads operands, so the W-1 MUL cycles must cover W multiplier bits:
   // the last cycle folds in the two remaining partial products at once.
   assign pp0        = mplier_q[0] ? mcand_q : '0;
   assign pp1        = mplier_q[1] ? (mcand_q << 1) : '0;
   assign prod_final = acc_q + pp0 + pp1;
   assign in_ready   = (state_q == S_IDLE);

   // multiplier sequencing registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
      end
   end

   // next state: start MUL or complete in place from IDLE, one shift-add step per MUL cycle
   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      mplier_d   = mplier_q;
      count_d    = count_q;
      done       = 1'b0;
      done_res   = '0;
      done_carry = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (func == F_MUL) begin
                  state_d  = S_MUL;
                  mcand_d  = {{W{1'b0}}, inputA};
                  mplier_d = inputB;
                  acc_d    = '0;
                  count_d  = CW'(W);
               end else begin
                  done       = 1'b1;
                  done_res   = op_res;
                  done_carry = op_carry;
               end
            end
         end
         S_MUL: begin
            count_d = count_q - CW'(1);
            if (count_q == CW'(2)) begin
               state_d    = S_IDLE;
               done       = 1'b1;
               done_res   = prod_final[W-1:0];
               done_carry = |prod_final[2*W-1:W];
            end else begin
               acc_d    = acc_q + pp0;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
`else
   assign in_ready = 1'b1;

   // every accepted request completes on its accept edge
   always_comb begin
      done       = accept;
      done_res   = op_res;
      done_carry = op_carry;
   end
`endif

   // a completion loads result and flags and pulses out_valid; otherwise everything holds
   always_comb begin
      result_d    = result_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      out_valid_d = done;
      if (done) begin
         result_d = done_res;
         carry_d  = done_carry;
         zero_d   = (done_res == '0);
         neg_d    = done_res[W-1];
      end
   end

   // output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign result    = result_q;
   assign carryOut  = carry_q;
   assign zero      = zero_q;
   assign negetive  = neg_q;
   assign out_valid = out_valid_q;

endmodule
